// File: rtl/candy_pkg.sv
`default_nettype none
// candy_pkg: shared state encoding, coin values and credit width for the vending controller.
package candy_pkg;

  localparam int CREDIT_W = 8;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = 8'd5;
  localparam logic [CREDIT_W-1:0] DIME_C    = 8'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_C = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tick_sync.sv
`default_nettype none
// tick_sync: 2-flop synchronizer plus rising-edge register; tick_o pulses one
// clk_i cycle, three cycles after a rising edge on sig_i.
module tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic tick_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/candy_vend_ctrl.sv
`default_nettype none
// candy_vend_ctrl: credit accumulation, timed dispense, change and idle-timeout refund.
// Define CANDY_CANCEL_EN to add the cancel input (refund from CREDIT).
module candy_vend_ctrl
  import candy_pkg::*;
#(
  parameter int unsigned PRICE          = 65,
  parameter int unsigned CREDIT_MAX     = 200,
  parameter int unsigned DISPENSE_TICKS = 15,
  parameter int unsigned TIMEOUT_TICKS  = 100
) (
  input  logic                clk_100MHz,
  input  logic                reset_n,
  input  logic                clk_10Hz,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
`ifdef CANDY_CANCEL_EN
  input  logic                cancel,
`endif
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_cents,
  output logic                refund,
  output logic                coin_reject
);

  localparam int unsigned MAX_TICKS =
    (DISPENSE_TICKS > TIMEOUT_TICKS) ? DISPENSE_TICKS : TIMEOUT_TICKS;
  localparam int CNT_W = $clog2(MAX_TICKS + 1);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic                dispense_q;
  logic                change_valid_q;
  logic [CREDIT_W-1:0] change_cents_q;
  logic                refund_q;
  logic                coin_reject_q;

  logic                tick;
  logic [CREDIT_W-1:0] coin_val;
  logic                coin_any;
  logic                coin_multi;
  logic                coin_open;
  logic                coin_take;
  logic                cancel_req;
  logic [CREDIT_W:0]   credit_sum_d;

  tick_sync u_tick_sync (
    .clk_i  (clk_100MHz),
    .rst_ni (reset_n),
    .sig_i  (clk_10Hz),
    .tick_o (tick)
  );

  // Priority quarter > dime > nickel; losers of a coincidence are rejected.
  assign coin_val   = coin_quarter ? QUARTER_C :
                      coin_dime    ? DIME_C    :
                      coin_nickel  ? NICKEL_C  : '0;
  assign coin_any   = coin_quarter | coin_dime | coin_nickel;
  assign coin_multi = (coin_quarter & coin_dime) | (coin_quarter & coin_nickel) |
                      (coin_dime & coin_nickel);

`ifdef CANDY_CANCEL_EN
  assign cancel_req = cancel && (state_q == ST_CREDIT);
`else
  assign cancel_req = 1'b0;
`endif

  assign coin_open    = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
  assign credit_sum_d = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_take    = coin_any && coin_open && !cancel_req &&
                        (credit_sum_d <= (CREDIT_W+1)'(CREDIT_MAX));

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      tick_cnt_q     <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_cents_q <= '0;
      refund_q       <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      change_valid_q <= 1'b0;
      coin_reject_q  <= coin_any && (!coin_take || coin_multi);

      case (state_q)
        ST_IDLE: begin
          if (coin_take) begin
            credit_q   <= credit_sum_d[CREDIT_W-1:0];
            tick_cnt_q <= '0;
            state_q    <= ST_CREDIT;
          end
        end

        ST_CREDIT: begin
          if (cancel_req) begin
            change_valid_q <= 1'b1;
            change_cents_q <= credit_q;
            refund_q       <= 1'b1;
            credit_q       <= '0;
            state_q        <= ST_IDLE;
          end else begin
            if (coin_take) begin
              credit_q   <= credit_sum_d[CREDIT_W-1:0];
              tick_cnt_q <= '0;
            end
            if (credit_q >= CREDIT_W'(PRICE)) begin
              state_q    <= ST_DISPENSE;
              dispense_q <= 1'b1;
              tick_cnt_q <= '0;
            end else if (!coin_take && tick) begin
              if (tick_cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                change_valid_q <= 1'b1;
                change_cents_q <= credit_q;
                refund_q       <= 1'b1;
                credit_q       <= '0;
                state_q        <= ST_IDLE;
              end else begin
                tick_cnt_q <= tick_cnt_q + CNT_W'(1);
              end
            end
          end
        end

        ST_DISPENSE: begin
          if (tick) begin
            if (tick_cnt_q == CNT_W'(DISPENSE_TICKS - 1)) begin
              state_q        <= ST_CHANGE;
              dispense_q     <= 1'b0;
              change_valid_q <= 1'b1;
              change_cents_q <= credit_q - CREDIT_W'(PRICE);
              refund_q       <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end
          end
        end

        ST_CHANGE: begin
          credit_q <= '0;
          state_q  <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_cents = change_cents_q;
  assign refund       = refund_q;
  assign coin_reject  = coin_reject_q;

endmodule
`default_nettype wire
